// File: rtl/jt49_bus_arb_if.sv
// rtl/jt49_bus_arb_if.sv - request/response port of the jt49 bus arbiter
interface jt49_bus_arb_if;
    logic       valid;
    logic       ready;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] din;
    logic       rsp;
    logic [7:0] rdata;

    modport master (
        output valid, rd, addr, din,
        input  ready, rsp, rdata
    );

    modport slave (
        input  valid, rd, addr, din,
        output ready, rsp, rdata
    );
endinterface

// File: rtl/jt49_bus_arb.sv
// rtl/jt49_bus_arb.sv - two-port round-robin arbiter and cs_n/wr_n sequencer for the jt49 PSG
module jt49_bus_arb #(
    parameter int unsigned WRLEN = 2,
    parameter int unsigned GAP   = 1
) (
    input  logic            clk,
    input  logic            rst,
    jt49_bus_arb_if.slave   a,
    jt49_bus_arb_if.slave   b,
    output logic            psg_cs_n,
    output logic            psg_wr_n,
    output logic [3:0]      psg_addr,
    output logic [7:0]      psg_din,
    input  logic [7:0]      psg_dout,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP
    } state_t;

    localparam logic [3:0] WR_LOAD  = 4'(WRLEN - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
    localparam logic [3:0] RD_LOAD  = 4'd1;

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       rr;
    logic       owner;
    logic       rd_q;
    logic [3:0] addr_q;
    logic [7:0] din_q;
    logic       a_rsp_q, b_rsp_q;
    logic [7:0] a_rdata_q, b_rdata_q;
    logic       cs_n_q, wr_n_q;

    logic       grant_a, grant_b;
    logic       a_ready, b_ready;
    logic       accept;
    logic       capture;

    // rr = 0 favours port A when both request, rr = 1 favours port B
    assign grant_b = b.valid && (!a.valid || rr);
    assign grant_a = a.valid && !grant_b;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        capture = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                a_ready = grant_a;
                b_ready = grant_b;
                if (grant_a || grant_b) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = rd_q ? RD_LOAD : WR_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt == 4'd0) begin
                    capture = rd_q;
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Strobes are registered from the next state so the PSG sees glitch-free edges
    // with the same cycle alignment as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q <= 1'b1;
            wr_n_q <= 1'b1;
        end else begin
            cs_n_q <= !(state_d == ST_SETUP || state_d == ST_STROBE);
            wr_n_q <= !(state_d == ST_STROBE && !rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            rr        <= 1'b0;
            owner     <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 4'd0;
            din_q     <= 8'd0;
            a_rsp_q   <= 1'b0;
            b_rsp_q   <= 1'b0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
        end else begin
            cnt     <= cnt_d;
            a_rsp_q <= 1'b0;
            b_rsp_q <= 1'b0;
            if (accept) begin
                owner  <= grant_b;
                rr     <= !grant_b;
                rd_q   <= grant_b ? b.rd   : a.rd;
                addr_q <= grant_b ? b.addr : a.addr;
                din_q  <= grant_b ? b.din  : a.din;
            end
            // Capture on the last read strobe cycle; the pulse lands in the first GAP cycle.
            if (capture) begin
                if (owner) begin
                    b_rdata_q <= psg_dout;
                    b_rsp_q   <= 1'b1;
                end else begin
                    a_rdata_q <= psg_dout;
                    a_rsp_q   <= 1'b1;
                end
            end
        end
    end

    assign a.ready  = a_ready;
    assign b.ready  = b_ready;
    assign a.rsp    = a_rsp_q;
    assign b.rsp    = b_rsp_q;
    assign a.rdata  = a_rdata_q;
    assign b.rdata  = b_rdata_q;

    assign psg_cs_n = cs_n_q;
    assign psg_wr_n = wr_n_q;
    assign psg_addr = addr_q;
    assign psg_din  = din_q;
    assign busy     = (state != ST_IDLE);

    wr_inside_cs: assert property (@(posedge clk) disable iff (rst) !psg_wr_n |-> !psg_cs_n);

endmodule

// File: tb/tb_jt49_bus_arb.sv
// tb/tb_jt49_bus_arb.sv - scoreboard bench for jt49_bus_arb
module tb_jt49_bus_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       psg_cs_n, psg_wr_n, busy;
    logic [3:0] psg_addr;
    logic [7:0] psg_din, psg_dout;
    logic       cs2, wr2, busy2;
    logic [3:0] addr2;
    logic [7:0] din2;
    logic [7:0] dout2;

    jt49_bus_arb_if a_if();
    jt49_bus_arb_if b_if();
    jt49_bus_arb_if c_if();
    jt49_bus_arb_if d_if();

    jt49_bus_arb dut (
        .clk(clk), .rst(rst), .a(a_if), .b(b_if),
        .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n), .psg_addr(psg_addr),
        .psg_din(psg_din), .psg_dout(psg_dout), .busy(busy)
    );

    jt49_bus_arb #(.WRLEN(5), .GAP(3)) dut2 (
        .clk(clk), .rst(rst), .a(c_if), .b(d_if),
        .psg_cs_n(cs2), .psg_wr_n(wr2), .psg_addr(addr2),
        .psg_din(din2), .psg_dout(dout2), .busy(busy2)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; logic [3:0] addr; logic [7:0] din; int start; } bus_t;
    typedef struct { bit port; logic [7:0] data; int at; } rsp_t;

    bus_t busq[$];
    rsp_t rspq[$];
    bus_t be;
    rsp_t re;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sends_a = 0, sends_b = 0, hs_a = 0, hs_b = 0;
    int env_restarts = 0;
    int stray_wr = 0;

    logic [7:0] regs [16];
    assign psg_dout = regs[psg_addr];
    assign dout2 = 8'hA5;

    always @(posedge clk) cyc++;

    always @(posedge clk)
        if (!psg_cs_n && !psg_wr_n) regs[psg_addr] <= psg_din;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endfunction

    // bus monitor: reconstructs each cs_n-low window and checks it against the queue
    bit         in_tx = 0, tx_ok, prev_wr_n = 1;
    int         tx_start, cs_len, wr_len;
    logic [3:0] tx_addr;
    logic [7:0] tx_din;

    always @(negedge clk) begin
        if (rst) begin
            in_tx = 0;
        end else if (!psg_cs_n) begin
            if (!in_tx) begin
                in_tx = 1; tx_start = cyc; cs_len = 0; wr_len = 0;
                tx_addr = psg_addr; tx_din = psg_din; tx_ok = 1;
            end
            cs_len++;
            if (!psg_wr_n) wr_len++;
            if (psg_addr != tx_addr || psg_din != tx_din) tx_ok = 0;
            if (!psg_wr_n && prev_wr_n && psg_addr == 4'd13) env_restarts++;
        end else begin
            if (!psg_wr_n) stray_wr++;
            if (in_tx) begin
                in_tx = 0;
                if (busq.size() == 0) begin
                    check("bus_unexpected_cycle", tx_start, -1);
                end else begin
                    be = busq.pop_front();
                    check("bus_addr", int'(tx_addr), int'(be.addr));
                    check("bus_din", int'(tx_din), int'(be.din));
                    check("bus_start_cycle", tx_start, be.start);
                    check("bus_cs_len", cs_len, be.rd ? 3 : 3);
                    check("bus_wr_len", wr_len, be.rd ? 0 : 2);
                    check("bus_addr_din_stable", int'(tx_ok), 1);
                end
            end
        end
        prev_wr_n = psg_wr_n;
    end

    always @(negedge clk) begin
        if (!rst && (a_if.rsp || b_if.rsp)) begin
            if (rspq.size() == 0) begin
                check("rsp_unexpected", int'({a_if.rsp, b_if.rsp}), 0);
            end else begin
                re = rspq.pop_front();
                check("rsp_port", int'(b_if.rsp), int'(re.port));
                check("rsp_single_port", int'(a_if.rsp && b_if.rsp), 0);
                check("rsp_cycle", cyc, re.at);
                check("rsp_rdata", int'(re.port ? b_if.rdata : a_if.rdata), int'(re.data));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.valid && a_if.ready) hs_a++;
            if (b_if.valid && b_if.ready) hs_b++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input bit rd, input logic [3:0] addr, input logic [7:0] din, input int start);
        bus_t e;
        e.rd = rd; e.addr = addr; e.din = din; e.start = start;
        busq.push_back(e);
    endtask

    task automatic push_rsp(input bit port, input logic [7:0] data, input int at);
        rsp_t e;
        e.port = port; e.data = data; e.at = at;
        rspq.push_back(e);
    endtask

    task automatic send(input bit port, input bit rd, input logic [3:0] addr, input logic [7:0] din);
        bit acc = 0;
        if (port) begin b_if.valid = 1; b_if.rd = rd; b_if.addr = addr; b_if.din = din; end
        else      begin a_if.valid = 1; a_if.rd = rd; a_if.addr = addr; a_if.din = din; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (port ? b_if.ready : a_if.ready) begin acc = 1; break; end
        end
        check(port ? "accept_b" : "accept_a", int'(acc), 1);
        @(posedge clk);
        #1;
        if (port) begin b_if.valid = 0; sends_b++; end
        else      begin a_if.valid = 0; sends_a++; end
    endtask

    task automatic run2(input bit rd, input logic [3:0] addr, input logic [7:0] din,
                        input int exp_cs, input int exp_wr, input int exp_busy, input int exp_rsp_at);
        int t = cyc;
        int cs_cnt = 0, wr_cnt = 0, busy_cnt = 0, first_wr = -1, rsp_at = -1;
        logic [7:0] rdv = 8'd0;
        c_if.valid = 1; c_if.rd = rd; c_if.addr = addr; c_if.din = din;
        @(negedge clk);
        check("d2_ready", int'(c_if.ready), 1);
        @(posedge clk);
        #1;
        c_if.valid = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (!cs2) cs_cnt++;
            if (!wr2) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc - t;
            end
            if (busy2) busy_cnt++;
            if (c_if.rsp) begin rsp_at = cyc - t; rdv = c_if.rdata; end
        end
        check("d2_cs_len", cs_cnt, exp_cs);
        check("d2_wr_len", wr_cnt, exp_wr);
        check("d2_busy_len", busy_cnt, exp_busy);
        check("d2_first_wr", first_wr, rd ? -1 : 2);
        check("d2_rsp_at", rsp_at, exp_rsp_at);
        if (rd) check("d2_rdata", int'(rdv), 8'hA5);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int env0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        {a_if.valid, a_if.rd, a_if.addr, a_if.din} = '0;
        {b_if.valid, b_if.rd, b_if.addr, b_if.din} = '0;
        {c_if.valid, c_if.rd, c_if.addr, c_if.din} = '0;
        {d_if.valid, d_if.rd, d_if.addr, d_if.din} = '0;
        rst = 1;
        step(3);
        @(negedge clk);
        check("rst_cs_n", int'(psg_cs_n), 1);
        check("rst_wr_n", int'(psg_wr_n), 1);
        check("rst_psg_addr", int'(psg_addr), 0);
        check("rst_psg_din", int'(psg_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp", int'({a_if.rsp, b_if.rsp}), 0);
        check("rst_a_rdata", int'(a_if.rdata), 0);
        check("rst_b_rdata", int'(b_if.rdata), 0);
        check("rst_ready", int'({a_if.ready, b_if.ready}), 0);
        step(1);
        rst = 0;
        step(1);

        // single write A: reg0 = 0x55, idle again 5 cycles after accept
        t = cyc;
        push_bus(0, 4'd0, 8'h55, t + 1);
        send(0, 0, 4'd0, 8'h55);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t1_busy", int'(busy), (k < 5) ? 1 : 0);
        end
        step(1);

        // B writes reg8 = 0x1F, then reads it back
        t = cyc;
        push_bus(0, 4'd8, 8'h1F, t + 1);
        send(1, 0, 4'd8, 8'h1F);
        step(4);
        t = cyc;
        push_bus(1, 4'd8, 8'h00, t + 1);
        push_rsp(1, 8'h1F, t + 4);
        send(1, 1, 4'd8, 8'h00);
        step(6);

        // three back-to-back envelope restarts
        env0 = env_restarts;
        t = cyc;
        push_bus(0, 4'd13, 8'h08, t + 1);
        push_bus(0, 4'd13, 8'h0A, t + 6);
        push_bus(0, 4'd13, 8'h0E, t + 11);
        send(0, 0, 4'd13, 8'h08);
        send(0, 0, 4'd13, 8'h0A);
        send(0, 0, 4'd13, 8'h0E);
        step(5);
        check("env_restarts", env_restarts - env0, 3);

        // both ports contending from rr=A: A,B,A,B... every 5 cycles
        rst = 1;
        step(1);
        rst = 0;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            push_bus(0, 4'(1 + k), 8'(8'h10 + k), t + 1 + 10 * k);
            push_bus(0, 4'(5 + k), 8'(8'h20 + k), t + 6 + 10 * k);
        end
        fork
            for (int k = 0; k < 4; k++) send(0, 0, 4'(1 + k), 8'(8'h10 + k));
            for (int m = 0; m < 4; m++) send(1, 0, 4'(5 + m), 8'(8'h20 + m));
        join
        step(6);

        // reset during the first read STROBE cycle aborts silently
        t = cyc;
        send(0, 1, 4'd0, 8'h00);
        step(1);
        rst = 1;
        step(1);
        rst = 0;
        @(negedge clk);
        check("abort_cs_n", int'(psg_cs_n), 1);
        check("abort_wr_n", int'(psg_wr_n), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_a_rdata", int'(a_if.rdata), 0);
        check("abort_b_rdata", int'(b_if.rdata), 0);
        step(2);
        t = cyc;
        push_bus(1, 4'd0, 8'h00, t + 1);
        push_rsp(0, 8'h55, t + 4);
        send(0, 1, 4'd0, 8'h00);
        step(8);

        // WRLEN=5, GAP=3 instance
        run2(0, 4'd3, 8'h77, 6, 5, 9, -1);
        check("d2_psg_addr", int'(addr2), 3);
        check("d2_psg_din", int'(din2), 8'h77);
        step(2);
        run2(1, 4'd5, 8'h00, 3, 0, 6, 4);

        check("bus_queue_drained", busq.size(), 0);
        check("rsp_queue_drained", rspq.size(), 0);
        check("handshakes_a", hs_a, sends_a);
        check("handshakes_b", hs_b, sends_b);
        check("wr_outside_cs", stray_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
